// File: rtl/mac_rx_pkg.sv
// Shared definitions for the MAC RX header-strip path: parser states,
// header geometry and byte-enable helpers.
package mac_rx_pkg;

    typedef enum logic [1:0] {
        ST_HDR0  = 2'd0,
        ST_HDR1  = 2'd1,
        ST_BODY  = 2'd2,
        ST_FLUSH = 2'd3
    } rx_state_e;

    localparam int ETH_HDR_BYTES     = 14;
    localparam int CARRY_BYTES       = 2;
    localparam int CNT_WIDTH_DEFAULT = 32;

    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rx_eth_hdr_strip.sv
// Strips the 14-byte Ethernet header from a 64-bit AXI-Stream frame,
// exposes it as sideband registers and re-emits the payload aligned to byte 0.
module rx_eth_hdr_strip
    import mac_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rx_axis_resetn,
    input  logic [DATA_WIDTH-1:0] s_rx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_rx_axis_tkeep,
    input  logic                  s_rx_axis_tvalid,
    input  logic                  s_rx_axis_tuser,
    input  logic                  s_rx_axis_tlast,
    output logic                  s_rx_axis_tready,
    output logic [DATA_WIDTH-1:0] m_pl_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_pl_axis_tkeep,
    output logic                  m_pl_axis_tvalid,
    output logic                  m_pl_axis_tuser,
    output logic                  m_pl_axis_tlast,
    input  logic                  m_pl_axis_tready,
    output logic [47:0]           hdr_dst_mac,
    output logic [47:0]           hdr_src_mac,
    output logic [15:0]           hdr_len_type,
    output logic                  hdr_valid,
    output logic [CNT_WIDTH-1:0]  frame_ok_cnt,
    output logic [CNT_WIDTH-1:0]  runt_cnt
);

    rx_state_e                state, state_nxt;
    logic [8*CARRY_BYTES-1:0] carry, carry_nxt;
    logic [1:0]               carry_n, carry_n_nxt;
    logic                     user_hold, user_hold_nxt;

    logic                  produce;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic                  beat_last, beat_user;
    logic                  cap_hdr0, cap_hdr1, hdr_pulse, runt_inc;

    logic       accept, out_free, ok_xfer;
    logic [3:0] in_n;
    logic [1:0] hi_n;

    // One output register stage: input and header beats both wait on it.
    assign out_free         = !m_pl_axis_tvalid || m_pl_axis_tready;
    assign s_rx_axis_tready = out_free && (state != ST_FLUSH);
    assign accept           = s_rx_axis_tvalid && s_rx_axis_tready;
    assign ok_xfer          = m_pl_axis_tvalid && m_pl_axis_tready && m_pl_axis_tlast && m_pl_axis_tuser;
    assign in_n             = keep_count(s_rx_axis_tkeep);
    assign hi_n             = {1'b0, s_rx_axis_tkeep[7]} + {1'b0, s_rx_axis_tkeep[6]};

    always_comb begin
        state_nxt     = state;
        carry_nxt     = carry;
        carry_n_nxt   = carry_n;
        user_hold_nxt = user_hold;
        produce       = 1'b0;
        beat_data     = '0;
        beat_keep     = '0;
        beat_last     = 1'b0;
        beat_user     = 1'b0;
        cap_hdr0      = 1'b0;
        cap_hdr1      = 1'b0;
        hdr_pulse     = 1'b0;
        runt_inc      = 1'b0;
        case (state)
            ST_HDR0: begin
                if (accept) begin
                    cap_hdr0 = 1'b1;
                    if (s_rx_axis_tlast) runt_inc  = 1'b1;
                    else                 state_nxt = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    cap_hdr1    = 1'b1;
                    carry_nxt   = s_rx_axis_tdata[63:48];
                    carry_n_nxt = hi_n;
                    if (s_rx_axis_tlast) begin
                        state_nxt = ST_HDR0;
                        if (hi_n == 2'd0) begin
                            runt_inc = 1'b1;
                        end else begin
                            // Whole payload fits in the tail of the second header beat.
                            hdr_pulse = 1'b1;
                            produce   = 1'b1;
                            beat_data = {48'h0, s_rx_axis_tdata[63:48]};
                            beat_keep = (hi_n == 2'd1) ? 8'h01 : 8'h03;
                            beat_last = 1'b1;
                            beat_user = s_rx_axis_tuser;
                        end
                    end else begin
                        hdr_pulse = 1'b1;
                        state_nxt = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    produce   = 1'b1;
                    beat_data = {s_rx_axis_tdata[47:0], carry};
                    beat_keep = {s_rx_axis_tkeep[5:0], 2'b11};
                    carry_nxt = s_rx_axis_tdata[63:48];
                    if (s_rx_axis_tlast) begin
                        if (in_n <= 4'd6) begin
                            beat_last = 1'b1;
                            beat_user = s_rx_axis_tuser;
                            state_nxt = ST_HDR0;
                        end else begin
                            user_hold_nxt = s_rx_axis_tuser;
                            carry_n_nxt   = 2'(in_n - 4'd6);
                            state_nxt     = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    produce   = 1'b1;
                    beat_data = {48'h0, carry};
                    beat_keep = (carry_n == 2'd1) ? 8'h01 : 8'h03;
                    beat_last = 1'b1;
                    beat_user = user_hold;
                    state_nxt = ST_HDR0;
                end
            end
            default: state_nxt = ST_HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rx_axis_resetn) begin
        if (!rx_axis_resetn) begin
            state     <= ST_HDR0;
            carry     <= '0;
            carry_n   <= '0;
            user_hold <= 1'b0;
        end else begin
            state     <= state_nxt;
            carry     <= carry_nxt;
            carry_n   <= carry_n_nxt;
            user_hold <= user_hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rx_axis_resetn) begin
        if (!rx_axis_resetn) begin
            m_pl_axis_tvalid <= 1'b0;
            m_pl_axis_tdata  <= '0;
            m_pl_axis_tkeep  <= '0;
            m_pl_axis_tlast  <= 1'b0;
            m_pl_axis_tuser  <= 1'b0;
        end else if (produce) begin
            m_pl_axis_tvalid <= 1'b1;
            m_pl_axis_tdata  <= beat_data;
            m_pl_axis_tkeep  <= beat_keep;
            m_pl_axis_tlast  <= beat_last;
            m_pl_axis_tuser  <= beat_user;
        end else if (m_pl_axis_tready) begin
            m_pl_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rx_axis_resetn) begin
        if (!rx_axis_resetn) begin
            hdr_dst_mac  <= '0;
            hdr_src_mac  <= '0;
            hdr_len_type <= '0;
            hdr_valid    <= 1'b0;
            frame_ok_cnt <= '0;
            runt_cnt     <= '0;
        end else begin
            hdr_valid <= hdr_pulse;
            if (cap_hdr0) begin
                hdr_dst_mac       <= s_rx_axis_tdata[47:0];
                hdr_src_mac[15:0] <= s_rx_axis_tdata[63:48];
            end
            if (cap_hdr1) begin
                hdr_src_mac[47:16] <= s_rx_axis_tdata[31:0];
                hdr_len_type       <= s_rx_axis_tdata[47:32];
            end
            if (runt_inc) runt_cnt     <= runt_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (ok_xfer)  frame_ok_cnt <= frame_ok_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_rx_eth_hdr_strip.sv
// Randomized bench for rx_eth_hdr_strip: frames are modelled as byte arrays,
// payload beats and header values are predicted from those bytes.
module tb_rx_eth_hdr_strip;

    localparam int W = 74; // {user, last, keep[7:0], data[63:0]}

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tuser, s_tlast, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tuser, m_tlast, m_tready;
    logic [47:0] hdr_dst, hdr_src;
    logic [15:0] hdr_lt;
    logic        hdr_valid;
    logic [31:0] ok_cnt, runt_cnt;

    always #5 clk = ~clk;

    rx_eth_hdr_strip dut (
        .clk              (clk),
        .rx_axis_resetn   (rst_n),
        .s_rx_axis_tdata  (s_tdata),
        .s_rx_axis_tkeep  (s_tkeep),
        .s_rx_axis_tvalid (s_tvalid),
        .s_rx_axis_tuser  (s_tuser),
        .s_rx_axis_tlast  (s_tlast),
        .s_rx_axis_tready (s_tready),
        .m_pl_axis_tdata  (m_tdata),
        .m_pl_axis_tkeep  (m_tkeep),
        .m_pl_axis_tvalid (m_tvalid),
        .m_pl_axis_tuser  (m_tuser),
        .m_pl_axis_tlast  (m_tlast),
        .m_pl_axis_tready (m_tready),
        .hdr_dst_mac      (hdr_dst),
        .hdr_src_mac      (hdr_src),
        .hdr_len_type     (hdr_lt),
        .hdr_valid        (hdr_valid),
        .frame_ok_cnt     (ok_cnt),
        .runt_cnt         (runt_cnt)
    );

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [W-1:0]   exp_q[$];
    logic [111:0]   hdr_q[$];
    int             exp_ok   = 0;
    int             exp_runt = 0;
    bit             rand_ready = 1'b0;
    int             low_cnt = 0;
    logic [7:0]     fb[0:255];
    bit             prev_stall = 1'b0;
    logic [W-1:0]   prev_beat;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_beat(input logic [63:0] d, input logic [7:0] k,
                                               input logic l, input logic u);
        logic [63:0] md;
        for (int i = 0; i < 8; i++) md[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        return {u & l, l, k, md};
    endfunction

    // Downstream ready: always-on or a fair coin per cycle.
    always @(posedge clk) begin
        #1;
        m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Output monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (!s_tready) low_cnt++;
            if (hdr_valid) begin
                if (hdr_q.size() == 0) check("hdr_unexpected", 1, 0);
                else check("hdr_fields", {hdr_lt, hdr_src, hdr_dst}, hdr_q.pop_front());
            end
            if (m_tvalid && prev_stall)
                check("stall_stable", pack_beat(m_tdata, m_tkeep, m_tlast, m_tuser), prev_beat);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                else check("payload_beat", pack_beat(m_tdata, m_tkeep, m_tlast, m_tuser), exp_q.pop_front());
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = pack_beat(m_tdata, m_tkeep, m_tlast, m_tuser);
        end
    end

    // Build a frame into fb and push the model's expectations.
    task automatic model_frame(input int len, input bit good, input logic [47:0] dst,
                               input logic [47:0] src, input logic [15:0] lt);
        logic [111:0] hdr;
        int p;
        hdr = {lt, src, dst};
        for (int i = 0; i < len; i++) fb[i] = (i < 14) ? hdr[8*i +: 8] : 8'($urandom);
        if (len <= 14) begin
            exp_runt++;
        end else begin
            hdr_q.push_back(hdr);
            p = len - 14;
            for (int off = 0; off < p; off += 8) begin
                logic [63:0] d;
                logic [7:0]  k;
                d = '0;
                k = '0;
                for (int j = 0; j < 8; j++) begin
                    if (off + j < p) begin
                        d[8*j +: 8] = fb[14 + off + j];
                        k[j] = 1'b1;
                    end
                end
                exp_q.push_back(pack_beat(d, k, off + 8 >= p, good));
            end
            if (good) exp_ok++;
        end
    endtask

    // Drive up to max_beats beats of the frame in fb.
    task automatic drive_frame(input int len, input bit good, input int max_beats);
        int beats = 0;
        for (int off = 0; off < len && beats < max_beats; off += 8) begin
            int t = 0;
            for (int j = 0; j < 8; j++) begin
                s_tdata[8*j +: 8] = (off + j < len) ? fb[off + j] : 8'h00;
                s_tkeep[j]        = (off + j < len);
            end
            s_tlast  = (off + 8 >= len);
            s_tuser  = s_tlast ? good : 1'b0;
            s_tvalid = 1'b1;
            @(negedge clk);
            while (!s_tready && t < 500) begin
                t++;
                @(negedge clk);
            end
            if (t >= 500) check("input_timeout", 0, 1);
            @(posedge clk);
            #1;
            beats++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit good, input logic [47:0] dst,
                              input logic [47:0] src, input logic [15:0] lt);
        model_frame(len, good, dst, src, lt);
        drive_frame(len, good, 1000);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0 || m_tvalid) && t < 3000) begin
            t++;
            @(posedge clk);
            #1;
        end
        if (t >= 3000) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ok_cnt"}, ok_cnt, exp_ok);
        check({tag, "_runt_cnt"}, runt_cnt, exp_runt);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_beat"}, {m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
        check({tag, "_hdr"}, {hdr_dst, hdr_src, hdr_lt, hdr_valid}, 0);
        check({tag, "_cnts"}, {ok_cnt, runt_cnt}, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 30-byte frame: two full payload beats
        send_frame(30, 1'b1, 48'd1, 48'd2, 16'd30);
        drain();
        check_counters("f30");

        // 32-byte frame: flush beat, one stalled input cycle
        low_cnt = 0;
        send_frame(32, 1'b1, 48'h0a0b0c0d0e0f, 48'h112233445566, 16'h0800);
        drain();
        check("f32_tready_low_cycles", low_cnt, 1);
        check_counters("f32");

        // Runt followed by minimal 15-byte frame
        send_frame(10, 1'b1, 48'h1, 48'h2, 16'h3);
        drain();
        check_counters("runt10");
        send_frame(15, 1'b1, 48'h4, 48'h5, 16'h6);
        drain();
        check_counters("f15");

        // Bad frame: forwarded, not counted
        send_frame(47, 1'b0, 48'hdead, 48'hbeef, 16'h86dd);
        drain();
        check_counters("bad");

        // Random frames under random backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            send_frame($urandom_range(15, 200), 1'b1, {$urandom, $urandom},
                       {$urandom, $urandom}, 16'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        drain();
        check_counters("random");
        rand_ready = 1'b0;

        // Reset asserted in the middle of a frame body
        model_frame(40, 1'b1, 48'h77, 48'h88, 16'h99);
        drive_frame(40, 1'b1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        exp_q.delete();
        hdr_q.delete();
        exp_ok   = 0;
        exp_runt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(30, 1'b1, 48'h123456789abc, 48'hcba987654321, 16'd30);
        drain();
        check_counters("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        check("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/rx_eth_hdr_strip.md
Name: rx_eth_hdr_strip

Overview:
- Sits directly downstream of the MAC RX AXI-Stream master (64-bit data, 8-bit tkeep, tuser=1 on tlast means good frame).
- Consumes each frame, extracts the 14-byte Ethernet header (destination MAC, source MAC, length/type) into sideband registers, then emits the payload realigned to byte 0 on a 64-bit AXI-Stream master.
- Drops runt frames and keeps frame statistics.

Parameters:
DATA_WIDTH, 64, stream data width; only 64 is supported.
KEEP_WIDTH, 8, byte-enable width; equals DATA_WIDTH/8.
CNT_WIDTH, 32, width of the statistics counters.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rx_axis_resetn  in  1  asynchronous, active-low reset.
s_rx_axis_tdata  in  64  input frame data; byte i is bits [8i+7:8i].
s_rx_axis_tkeep  in  8  input byte enables; always low-contiguous.
s_rx_axis_tvalid  in  1  input beat valid.
s_rx_axis_tuser  in  1  good-frame flag; sampled on tlast only.
s_rx_axis_tlast  in  1  last beat of frame.
s_rx_axis_tready  out  1  input ready.
m_pl_axis_tdata  out  64  payload data, realigned.
m_pl_axis_tkeep  out  8  payload byte enables.
m_pl_axis_tvalid  out  1  payload beat valid.
m_pl_axis_tuser  out  1  good flag, meaningful on tlast.
m_pl_axis_tlast  out  1  last payload beat.
m_pl_axis_tready  in  1  downstream ready.
hdr_dst_mac  out  48  input beat0 bits [47:0].
hdr_src_mac  out  48  {beat1[31:0], beat0[63:48]}.
hdr_len_type  out  16  input beat1 bits [47:32]; not byte-swapped.
hdr_valid  out  1  one-cycle pulse when beat1 of a frame with payload is accepted.
frame_ok_cnt  out  CNT_WIDTH  count of frames forwarded with tuser=1; wraps.
runt_cnt  out  CNT_WIDTH  count of dropped frames; wraps.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs go to 0.
  - State HDR0; carry register and counters 0.
- Input acceptance:
  - A beat transfers when tvalid && tready.
  - s_rx_axis_tready = (!m_pl_axis_tvalid || m_pl_axis_tready) && state != FLUSH.
  - Headers are absorbed under the same rule; this is a single output register stage.
- Output register:
  - Loads when a beat is produced.
  - Holds data/keep/last/user stable while tvalid && !tready.
  - Clears tvalid on transfer when there is no new beat.
- States:
  - HDR0, accept:
    - Capture hdr_dst_mac and src[15:0].
    - If tlast: runt_cnt++, stay in HDR0, emit nothing.
    - Else go to HDR1.
  - HDR1, accept:
    - Capture src[47:16] and len_type.
    - carry <= tdata[63:48]; carry_n <= number of set bits in tkeep[7:6].
    - If tlast && carry_n==0: runt_cnt++, go to HDR0, no hdr_valid.
    - If tlast && carry_n>0: pulse hdr_valid and emit {48'h0, carry bytes}; keep = 8'h01 (carry_n=1) or 8'h03 (carry_n=2); tlast=1; tuser=in tuser. Go to HDR0.
    - Else: pulse hdr_valid and go to BODY.
  - BODY, accept a beat with n bytes:
    - Emit data = {in[47:0], carry}, keep = {in_keep[5:0], 2'b11}.
    - carry <= in[63:48].
    - If tlast && n<=6: output tlast=1, tuser=in tuser; go to HDR0.
    - If tlast && n>6: output tlast=0; latch tuser; carry_n <= n-6; go to FLUSH.
  - FLUSH:
    - Input not ready.
    - When the output register is free, emit {48'h0, carry}; keep = 8'h01 (carry_n=1) or 8'h03 (carry_n=2); tlast=1; tuser=latched.
    - Go to HDR0.
- Payload byte count equals input frame bytes minus 14.
- Latency: 1 cycle from input accept to m_pl_axis_tvalid.
- frame_ok_cnt increments when an output tlast beat with tuser=1 transfers. Bad frames are forwarded, not counted.
- Header outputs hold until overwritten by the next frame.
- Simultaneous tlast on input and output backpressure: no input loss; the FLUSH beat waits.
- Reset mid-frame: the partial frame is discarded. After release the block expects a new frame at HDR0 and emits no stale output beat.
- Non-contiguous tkeep: output undefined (a protocol violation upstream).

Decomposition:
- Shared package mac_rx_pkg holds:
  - state encoding (HDR0, HDR1, BODY, FLUSH);
  - ETH_HDR_BYTES=14, CARRY_BYTES=2;
  - keep-to-count function;
  - counter width default.
- No sub-module: the output register stage stays inline.

Test Plan:
- Frame dst=1, src=2, len_type=30, 30 total bytes (4 beats, last keep 8'h3F):
  - hdr_valid pulses once with hdr_dst_mac=1, hdr_src_mac=2, hdr_len_type=30.
  - 16 payload bytes in 2 beats, keep FF then FF; tlast on 2nd; tuser=1; frame_ok_cnt=1.
- 32-byte frame (last keep 8'hFF):
  - 3 payload beats, keep FF, FF, 03; FLUSH beat carries beat3 bytes 6..7.
  - s_tready low for exactly 1 cycle.
- 10-byte frame (tlast on beat1, keep 8'h03):
  - No output, no hdr_valid, runt_cnt=1.
  - A following 15-byte frame yields one output beat, keep 8'h01, tlast=1.
- Random m_pl_axis_tready (50%) over 100 frames of 15..200 bytes:
  - Payload bytes match the scoreboard.
  - Output held stable while stalled; frame_ok_cnt=100.
- Bad frame (tuser=0 on tlast): payload forwarded with tuser=0 on tlast; frame_ok_cnt unchanged.
- rx_axis_resetn asserted mid-BODY:
  - Outputs 0 immediately.
  - After release, the next 30-byte frame is parsed correctly with no residual beat.
